// File: rtl/cla12_mp_sequencer.sv
// Multi-precision add sequencer feeding an external cla12, one 12-bit slice per clock, LSW first.
// Optional subtract mode is enabled by defining CLA12_MP_SUB_EN (adds the sub input port).
module cla12_mp_sequencer #(
  parameter int WORDS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [12*WORDS-1:0]   a,
  input  logic [12*WORDS-1:0]   b,
  input  logic                  cin,
`ifdef CLA12_MP_SUB_EN
  input  logic                  sub,
`endif
  output logic [11:0]           add_a,
  output logic [11:0]           add_b,
  output logic                  add_cin,
  input  logic [11:0]           add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [12*WORDS-1:0]   result,
  output logic                  cout
);

  localparam int W  = 12 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic            carry_reg;
  logic            cout_reg;
  logic [W-1:0]    a_reg, b_reg;
  logic [11:0]     result_sl_reg [WORDS];
  logic [11:0]     a_sl [WORDS];
  logic [11:0]     b_sl [WORDS];
  logic            sub_reg;
  logic            accept;

  // Slice views of the latched operands and the assembled result.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_slice
      assign a_sl[gi] = a_reg[gi*12 +: 12];
      assign b_sl[gi] = b_reg[gi*12 +: 12];
      assign result[gi*12 +: 12] = result_sl_reg[gi];
    end
  endgenerate

  assign cout = cout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        add_a   = a_sl[cnt_reg];
        add_b   = b_sl[cnt_reg] ^ {12{sub_reg}};
        add_cin = carry_reg;
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CLA12_MP_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sub_reg <= 1'b0;
    else if (accept) sub_reg <= sub;
  end
  // Subtraction is A + ~B + 1, so the initial carry is forced high.
  wire carry_init = sub ? 1'b1 : cin;
`else
  assign sub_reg = 1'b0;
  wire carry_init = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      for (int i = 0; i < WORDS; i++) result_sl_reg[i] <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= carry_init;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      result_sl_reg[cnt_reg] <= add_sum;
      carry_reg              <= add_cout;
      cnt_reg                <= cnt_reg + CW'(1);
      if (cnt_reg == LAST) cout_reg <= add_cout;
    end
  end

endmodule

// File: tb/tb_cla12_mp_sequencer.sv
// Self-checking bench for cla12_mp_sequencer (WORDS=3) with a behavioural cla12 stand-in.
// Exercises subtract mode as well when CLA12_MP_SUB_EN is defined.
module tb_cla12_mp_sequencer;
  localparam int WORDS = 3;
  localparam int W     = 12 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0;
  logic          cin = 1'b0;
`ifdef CLA12_MP_SUB_EN
  logic          sub = 1'b0;
`endif
  logic [11:0]   add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in for the external cla12 adder.
  assign {add_cout, add_sum} = 13'(add_a) + 13'(add_b) + 13'(add_cin);

  cla12_mp_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef CLA12_MP_SUB_EN
    .sub(sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // Reference: full-width arithmetic on the operands, independent of slicing.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  // One complete request/response; inputs are scrambled after capture to prove they are ignored.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       input logic xs, input int hold);
    logic [W:0] exp;
    int n;
    exp = model(xa, xb, xc, xs);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    check("add_a_idle", 64'(add_a), 64'(0));
    in_valid = 1'b1; a = xa; b = xb; cin = xc;
`ifdef CLA12_MP_SUB_EN
    sub = xs;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0; a = rand_w(); b = rand_w(); cin = 1'($urandom_range(0, 1));
`ifdef CLA12_MP_SUB_EN
    sub = 1'($urandom_range(0, 1));
`endif
    check("in_ready_run", 64'(in_ready), 64'(0));
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    // WORDS edges after the accept edge, i.e. WORDS+1 cycles counted from the accept cycle.
    check("latency", 64'(n), 64'(WORDS));
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_result", 64'(result), 64'(exp[W-1:0]));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    check("result", 64'(result), 64'(exp[W-1:0]));
    check("cout", 64'(cout), 64'(exp[W]));
    $display("op a=%h b=%h cin=%0d sub=%0d hold=%0d -> result=%h cout=%0d",
             xa, xb, xc, xs, hold, result, cout);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'(0));
  endtask

  initial begin
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(36'd15, 36'd1795, 1'b0, 1'b0, 0);
    do_op(36'hFFFFFFFFF, 36'd1, 1'b0, 1'b0, 0);
    do_op(36'd0, 36'd0, 1'b1, 1'b0, 0);
    do_op(36'd11, 36'd3311, 1'b1, 1'b0, 0);
    do_op(36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b1, 1'b0, 5);
    do_op(36'h000FFF000, 36'h000001000, 1'b0, 1'b0, 5);

    // Reset during the second RUN cycle aborts with no output.
    in_valid = 1'b1; a = 36'h123456789; b = 36'h0ABCDEF01; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_output", 64'(out_valid), 64'(0));
    do_op(36'd12, 36'd14, 1'b0, 1'b0, 0);

`ifdef CLA12_MP_SUB_EN
    do_op(36'd12, 36'd14, 1'b0, 1'b1, 0);
    do_op(36'd353, 36'd7, 1'b0, 1'b1, 2);
`endif

    for (int t = 0; t < 24; t++) begin
      logic s;
      s = 1'b0;
`ifdef CLA12_MP_SUB_EN
      s = 1'($urandom_range(0, 1));
`endif
      do_op(rand_w(), rand_w(), 1'($urandom_range(0, 1)), s, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
